// File: rtl/bullet_slot_arbiter.sv
// rtl/bullet_slot_arbiter.sv - round-robin bullet slot allocator with occupancy tracking
module bullet_slot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_SLOT = 16,
    parameter int SLOT_W   = 4
) (
    input  logic                clk,
    input  logic                hard_reset,
    input  logic                game_en,
    input  logic                game_reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                release_valid,
    input  logic [SLOT_W-1:0]   release_slot,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_valid,
    output logic [SLOT_W-1:0]   grant_slot,
    output logic [NUM_SLOT-1:0] slot_busy,
    output logic [SLOT_W:0]     free_count,
    output logic                pool_empty,
    output logic                err_release
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  grant_valid_q, grant_valid_d;
    logic [SLOT_W-1:0]     grant_slot_q, grant_slot_d;
    logic [NUM_SLOT-1:0]   slot_busy_q, slot_busy_d;
    logic [SLOT_W:0]       free_count_q, free_count_d;
    logic                  pool_empty_q, pool_empty_d;
    logic                  err_q, err_d;
    logic [RR_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [2*NUM_REQ-1:0]  req_dbl;
    logic [NUM_REQ-1:0]    rot_req;
    logic [RR_W-1:0]       win_off;
    logic [RR_W:0]         win_sum;
    logic [RR_W-1:0]       winner;
    logic [SLOT_W-1:0]     free_idx;
    logic                  any_free;
    logic                  arb_en;
    logic                  do_grant;
    logic                  rel_hit;
    logic                  rel_miss;
    logic [NUM_SLOT-1:0]   rel_mask;
    logic [NUM_SLOT-1:0]   gnt_mask;

    // Rotate requests so the search always starts at bit 0, then pick the first set bit.
    always_comb begin
        req_dbl = {req, req} >> rr_ptr_q;
        rot_req = req_dbl[NUM_REQ-1:0];
        win_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = RR_W'(i);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= (RR_W+1)'(NUM_REQ)) begin
            win_sum = win_sum - (RR_W+1)'(NUM_REQ);
        end
        winner = win_sum[RR_W-1:0];
    end

    // Lowest-index free slot, taken from the registered map so a slot released
    // this cycle cannot be handed out until the next one.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOT - 1; i >= 0; i--) begin
            if (!slot_busy_q[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
        any_free = ~&slot_busy_q;
    end

    // Qualify grant and release events; game_reset overrides everything.
    always_comb begin
        arb_en   = (state_q == ST_RUN) && game_en && !game_reset;
        do_grant = arb_en && (|req) && any_free;
        rel_hit  = !game_reset && release_valid && slot_busy_q[release_slot];
        rel_miss = !game_reset && release_valid && !slot_busy_q[release_slot];
        rel_mask = rel_hit  ? (NUM_SLOT'(1) << release_slot) : '0;
        gnt_mask = do_grant ? (NUM_SLOT'(1) << free_idx)     : '0;
    end

    // Next-state logic for the control FSM and all registered outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_slot_d  = '0;
        slot_busy_d   = slot_busy_q;
        free_count_d  = free_count_q;
        err_d         = err_q;
        rr_ptr_d      = rr_ptr_q;

        if (game_reset) begin
            state_d      = ST_FLUSH;
            slot_busy_d  = '0;
            free_count_d = (SLOT_W+1)'(NUM_SLOT);
            err_d        = 1'b0;
            rr_ptr_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = game_en ? ST_RUN : ST_IDLE;
                ST_RUN:   state_d = game_en ? ST_RUN : ST_IDLE;
                ST_FLUSH: state_d = game_en ? ST_RUN : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase

            if (do_grant) begin
                grant_d        = NUM_REQ'(1) << winner;
                grant_valid_d  = 1'b1;
                grant_slot_d   = free_idx;
                rr_ptr_d       = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end

            slot_busy_d  = (slot_busy_q | gnt_mask) & ~rel_mask;
            free_count_d = free_count_q + {{SLOT_W{1'b0}}, rel_hit}
                                        - {{SLOT_W{1'b0}}, do_grant};
            if (rel_miss) begin
                err_d = 1'b1;
            end
        end

        pool_empty_d = (free_count_d == '0);
    end

    // State and output registers with synchronous hard reset.
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_slot_q  <= '0;
            slot_busy_q   <= '0;
            free_count_q  <= (SLOT_W+1)'(NUM_SLOT);
            pool_empty_q  <= 1'b0;
            err_q         <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_slot_q  <= grant_slot_d;
            slot_busy_q   <= slot_busy_d;
            free_count_q  <= free_count_d;
            pool_empty_q  <= pool_empty_d;
            err_q         <= err_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_slot  = grant_slot_q;
    assign slot_busy   = slot_busy_q;
    assign free_count  = free_count_q;
    assign pool_empty  = pool_empty_q;
    assign err_release = err_q;

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// tb/tb_bullet_slot_arbiter.sv - directed self-checking bench for bullet_slot_arbiter
module tb_bullet_slot_arbiter;

    logic        clk;
    logic        hard_reset;
    logic        game_en;
    logic        game_reset;
    logic [3:0]  req;
    logic        release_valid;
    logic [3:0]  release_slot;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [3:0]  grant_slot;
    logic [15:0] slot_busy;
    logic [4:0]  free_count;
    logic        pool_empty;
    logic        err_release;

    int checks;
    int errors;

    bullet_slot_arbiter #(
        .NUM_REQ  (4),
        .NUM_SLOT (16),
        .SLOT_W   (4)
    ) dut (
        .clk           (clk),
        .hard_reset    (hard_reset),
        .game_en       (game_en),
        .game_reset    (game_reset),
        .req           (req),
        .release_valid (release_valid),
        .release_slot  (release_slot),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_slot    (grant_slot),
        .slot_busy     (slot_busy),
        .free_count    (free_count),
        .pool_empty    (pool_empty),
        .err_release   (err_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [3:0] s,
                             input logic [4:0] fc);
        chk({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
        chk({tag, "_gvalid"}, {31'd0, grant_valid}, {31'd0, |g});
        if (g != 4'd0) chk({tag, "_slot"}, {28'd0, grant_slot}, {28'd0, s});
        chk({tag, "_free"}, {27'd0, free_count}, {27'd0, fc});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        hard_reset    = 1'b1;
        game_en       = 1'b0;
        game_reset    = 1'b0;
        req           = 4'b0000;
        release_valid = 1'b0;
        release_slot  = 4'd0;
        step();
        step();
        hard_reset = 1'b0;

        chk("rst_grant", {28'd0, grant}, 32'h0);
        chk("rst_gvalid", {31'd0, grant_valid}, 32'h0);
        chk("rst_gslot", {28'd0, grant_slot}, 32'h0);
        chk("rst_busy", {16'd0, slot_busy}, 32'h0);
        chk("rst_free", {27'd0, free_count}, 32'd16);
        chk("rst_empty", {31'd0, pool_empty}, 32'h0);
        chk("rst_err", {31'd0, err_release}, 32'h0);

        // 1: single requester gets slots 0,1,2 back to back
        game_en = 1'b1;
        step();
        chk_grant("t1_enter", 4'b0000, 4'd0, 5'd16);
        req = 4'b0001;
        step(); chk_grant("t1_g0", 4'b0001, 4'd0, 5'd15);
        step(); chk_grant("t1_g1", 4'b0001, 4'd1, 5'd14);
        step(); chk_grant("t1_g2", 4'b0001, 4'd2, 5'd13);
        req = 4'b0000;
        step(); chk_grant("t1_idle", 4'b0000, 4'd0, 5'd13);
        chk("t1_busy", {16'd0, slot_busy}, 32'h0007);

        // 2: all four requesters drain a fresh pool in rotation
        hard_reset = 1'b1;
        step();
        hard_reset = 1'b0;
        game_en = 1'b1;
        step();
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            step();
            chk_grant($sformatf("t2_g%0d", k), 4'(1 << (k % 4)), 4'(k), 5'(15 - k));
            chk($sformatf("t2_empty%0d", k), {31'd0, pool_empty}, {31'd0, (k == 15)});
        end
        step();
        chk_grant("t2_full", 4'b0000, 4'd0, 5'd0);
        chk("t2_busy", {16'd0, slot_busy}, 32'hFFFF);
        chk("t2_empty_hold", {31'd0, pool_empty}, 32'h1);

        // 3: release on a full pool is not reusable the same cycle
        req           = 4'b0010;
        release_valid = 1'b1;
        release_slot  = 4'd5;
        step();
        chk_grant("t3_same", 4'b0000, 4'd0, 5'd1);
        chk("t3_busy_rel", {16'd0, slot_busy}, 32'hFFDF);
        chk("t3_empty_rel", {31'd0, pool_empty}, 32'h0);
        release_valid = 1'b0;
        step();
        chk_grant("t3_next", 4'b0010, 4'd5, 5'd0);
        chk("t3_busy", {16'd0, slot_busy}, 32'hFFFF);
        req = 4'b0000;

        // 4: good release then a bad release of the same slot
        release_valid = 1'b1;
        release_slot  = 4'd7;
        step();
        chk("t4_busy_ok", {16'd0, slot_busy}, 32'hFF7F);
        chk("t4_err_ok", {31'd0, err_release}, 32'h0);
        step();
        chk("t4_busy_bad", {16'd0, slot_busy}, 32'hFF7F);
        chk("t4_free_bad", {27'd0, free_count}, 32'd1);
        chk("t4_err_set", {31'd0, err_release}, 32'h1);
        release_valid = 1'b0;
        step();
        chk("t4_err_sticky", {31'd0, err_release}, 32'h1);

        // grant and release in the same cycle: rr_ptr=2, only req0 -> winner 0, slot 7
        req           = 4'b0001;
        release_valid = 1'b1;
        release_slot  = 4'd3;
        step();
        chk_grant("t4_both", 4'b0001, 4'd7, 5'd1);
        chk("t4_both_busy", {16'd0, slot_busy}, 32'hFFF7);
        req           = 4'b0000;
        release_valid = 1'b0;
        step();

        // 5: game_reset beats a concurrent request and flushes the pool
        game_reset = 1'b1;
        req        = 4'b0001;
        step();
        chk_grant("t5_flush", 4'b0000, 4'd0, 5'd16);
        chk("t5_busy", {16'd0, slot_busy}, 32'h0);
        chk("t5_err_clr", {31'd0, err_release}, 32'h0);
        chk("t5_empty", {31'd0, pool_empty}, 32'h0);
        game_reset = 1'b0;
        step();
        chk_grant("t5_exit", 4'b0000, 4'd0, 5'd16);
        step();
        chk_grant("t5_first", 4'b0001, 4'd0, 5'd15);
        req = 4'b0000;

        // 6: frozen arbitration still honours releases; re-enable resumes grants
        game_en = 1'b0;
        req     = 4'b0100;
        step();
        chk_grant("t6_frz0", 4'b0000, 4'd0, 5'd15);
        step();
        chk_grant("t6_frz1", 4'b0000, 4'd0, 5'd15);
        release_valid = 1'b1;
        release_slot  = 4'd0;
        step();
        chk("t6_rel_busy", {16'd0, slot_busy}, 32'h0);
        chk_grant("t6_rel", 4'b0000, 4'd0, 5'd16);
        release_valid = 1'b0;
        game_en = 1'b1;
        step();
        chk_grant("t6_wake", 4'b0000, 4'd0, 5'd16);
        step();
        chk_grant("t6_go", 4'b0100, 4'd0, 5'd15);
        req = 4'b0000;
        step();
        chk_grant("t6_done", 4'b0000, 4'd0, 5'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
